// File: rtl/down_timer.sv
// Loadable down-counting timer: terminal-count pulse, one-shot DONE state and
// optional auto-reload at terminal count, enabled by defining TIMER_AUTORELOAD_EN.
module down_timer #(
    parameter int WIDTH = 5
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] cnt_in,
    input  logic             load,
    input  logic             enab,
    input  logic             reload,
    output logic [WIDTH-1:0] cnt_out,
    output logic             tc,
    output logic             busy,
    output logic             done
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           state, state_nxt;
    logic [WIDTH-1:0] cnt_nxt;
    logic             tc_nxt;
    logic             reload_hit;
    logic [WIDTH-1:0] rld_val;

`ifdef TIMER_AUTORELOAD_EN
    logic [WIDTH-1:0] rld_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            rld_q <= '0;
        else if (load)
            rld_q <= cnt_in;
    end

    assign reload_hit = reload;
    assign rld_val    = rld_q;
`else
    // Strictly one-shot build: reload input has no effect.
    logic unused_reload;
    assign unused_reload = reload;
    assign reload_hit    = 1'b0;
    assign rld_val       = '0;
`endif

    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt_out;
        tc_nxt    = 1'b0;
        if (load) begin
            cnt_nxt   = cnt_in;
            state_nxt = (cnt_in != '0) ? RUN : IDLE;
        end else if (state == RUN && enab) begin
            if (cnt_out > WIDTH'(1)) begin
                cnt_nxt = cnt_out - WIDTH'(1);
            end else begin
                // cnt_out is 1 here: a zero load never enters RUN.
                tc_nxt = 1'b1;
                if (reload_hit) begin
                    cnt_nxt = rld_val;
                end else begin
                    cnt_nxt   = '0;
                    state_nxt = DONE;
                end
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= IDLE;
            cnt_out <= '0;
            tc      <= 1'b0;
            busy    <= 1'b0;
            done    <= 1'b0;
        end else begin
            state   <= state_nxt;
            cnt_out <= cnt_nxt;
            tc      <= tc_nxt;
            busy    <= (state_nxt == RUN);
            done    <= (state_nxt == DONE);
        end
    end

endmodule

// File: tb/tb_down_timer.sv
// Self-checking bench for down_timer: directed scenarios plus randomized
// traffic against a behavioural model; follows TIMER_AUTORELOAD_EN if defined.
module tb_down_timer;

    localparam int W = 5;
`ifdef TIMER_AUTORELOAD_EN
    localparam bit AR = 1'b1;
`else
    localparam bit AR = 1'b0;
`endif

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic [W-1:0] cnt_in = '0;
    logic         load = 1'b0, enab = 1'b0, reload = 1'b0;
    logic [W-1:0] cnt_out;
    logic         tc, busy, done;

    int checks = 0;
    int errors = 0;

    // Reference model: remaining count, phase (0 idle, 1 counting, 2 finished)
    int m_cnt, m_phase, m_period;
    bit m_tc;

    down_timer #(.WIDTH(W)) dut (
        .clk(clk), .rst(rst), .cnt_in(cnt_in), .load(load), .enab(enab),
        .reload(reload), .cnt_out(cnt_out), .tc(tc), .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    function automatic logic [7:0] v(input int c, input bit t, input bit b, input bit d);
        return {W'(c), t, b, d};
    endfunction

    function automatic logic [7:0] mv();
        return v(m_cnt, m_tc, m_phase == 1, m_phase == 2);
    endfunction

    task automatic model_reset();
        m_cnt = 0; m_phase = 0; m_period = 0; m_tc = 0;
    endtask

    task automatic model_step(input bit ld, input int ci, input bit en, input bit rl);
        m_tc = 0;
        if (ld) begin
            m_cnt = ci; m_period = ci; m_phase = (ci != 0) ? 1 : 0;
        end else if (m_phase == 1 && en) begin
            m_cnt = m_cnt - 1;
            if (m_cnt == 0) begin
                m_tc = 1;
                if (AR && rl) m_cnt = m_period;
                else m_phase = 2;
            end
        end
    endtask

    // One clock: drive inputs, advance model at the edge, settle 1ns after it.
    task automatic tick(input bit ld, input int ci, input bit en, input bit rl);
        load = ld; cnt_in = W'(ci); enab = en; reload = rl;
        @(posedge clk);
        model_step(ld, ci, en, rl);
        #1;
        load = 0; enab = 0; reload = 0;
    endtask

    task automatic test_reset();
        #3;
        checks++;
        if ({cnt_out, tc, busy, done} !== v(0, 0, 0, 0)) begin
            errors++; $display("FAIL reset_state got %h exp %h", {cnt_out, tc, busy, done}, v(0, 0, 0, 0));
        end
        @(posedge clk); #1;
        rst = 0;
        model_reset();
    endtask

    task automatic test_reset_mid_count();
        tick(1, 9, 0, 0);
        for (int i = 0; i < 3; i++) tick(0, 0, 1, 0);
        checks++;
        if ({cnt_out, tc, busy, done} !== v(6, 0, 1, 0)) begin
            errors++; $display("FAIL pre_reset got %h exp %h", {cnt_out, tc, busy, done}, v(6, 0, 1, 0));
        end
        #2 rst = 1;
        #1;
        checks++;
        if ({cnt_out, tc, busy, done} !== v(0, 0, 0, 0)) begin
            errors++; $display("FAIL async_reset got %h exp %h", {cnt_out, tc, busy, done}, v(0, 0, 0, 0));
        end
        @(posedge clk); #1;
        rst = 0;
        model_reset();
        for (int i = 0; i < 3; i++) tick(0, 0, 1, 1);
        checks++;
        if ({cnt_out, tc, busy, done} !== v(0, 0, 0, 0)) begin
            errors++; $display("FAIL enab_after_reset got %h exp %h", {cnt_out, tc, busy, done}, v(0, 0, 0, 0));
        end
    endtask

    task automatic test_one_shot();
        logic [7:0] ev [8];
        ev = '{v(5,0,1,0), v(4,0,1,0), v(3,0,1,0), v(2,0,1,0),
               v(1,0,1,0), v(0,1,0,1), v(0,0,0,1), v(0,0,0,1)};
        for (int i = 0; i < 8; i++) begin
            tick(i == 0, 5, i != 0, 0);
            checks++;
            if ({cnt_out, tc, busy, done} !== ev[i]) begin
                errors++; $display("FAIL one_shot[%0d] got %h exp %h", i, {cnt_out, tc, busy, done}, ev[i]);
            end
        end
    endtask

    task automatic test_pause();
        logic [7:0] ev [7];
        bit         en [7];
        ev = '{v(4,0,1,0), v(3,0,1,0), v(3,0,1,0), v(3,0,1,0),
               v(2,0,1,0), v(1,0,1,0), v(0,1,0,1)};
        en = '{0, 1, 0, 0, 1, 1, 1};
        for (int i = 0; i < 7; i++) begin
            tick(i == 0, 4, en[i], 0);
            checks++;
            if ({cnt_out, tc, busy, done} !== ev[i]) begin
                errors++; $display("FAIL pause[%0d] got %h exp %h", i, {cnt_out, tc, busy, done}, ev[i]);
            end
        end
    endtask

    task automatic test_collision_zero_load();
        logic [7:0] ev [5];
        ev = '{v(3,0,1,0), v(2,0,1,0), v(1,0,1,0), v(7,0,1,0), v(0,0,0,0)};
        tick(1, 3, 0, 0);
        tick(0, 0, 1, 0);
        tick(0, 0, 1, 0);
        tick(1, 7, 1, 0);
        tick(1, 0, 1, 0);
        // Replay to check each step in order from a fresh load.
        for (int i = 0; i < 5; i++) begin
            case (i)
                0: tick(1, 3, 0, 0);
                1, 2: tick(0, 0, 1, 0);
                3: tick(1, 7, 1, 0);
                default: tick(1, 0, 1, 0);
            endcase
            checks++;
            if ({cnt_out, tc, busy, done} !== ev[i]) begin
                errors++; $display("FAIL collision[%0d] got %h exp %h", i, {cnt_out, tc, busy, done}, ev[i]);
            end
        end
        tick(0, 0, 1, 1);
        checks++;
        if ({cnt_out, tc, busy, done} !== v(0, 0, 0, 0)) begin
            errors++; $display("FAIL idle_hold got %h exp %h", {cnt_out, tc, busy, done}, v(0, 0, 0, 0));
        end
    endtask

    task automatic test_auto_reload();
        logic [7:0] ev [10];
        if (AR)
            ev = '{v(3,0,1,0), v(2,0,1,0), v(1,0,1,0), v(3,1,1,0), v(2,0,1,0),
                   v(1,0,1,0), v(3,1,1,0), v(2,0,1,0), v(1,0,1,0), v(0,1,0,1)};
        else
            ev = '{v(3,0,1,0), v(2,0,1,0), v(1,0,1,0), v(0,1,0,1), v(0,0,0,1),
                   v(0,0,0,1), v(0,0,0,1), v(0,0,0,1), v(0,0,0,1), v(0,0,0,1)};
        for (int i = 0; i < 10; i++) begin
            tick(i == 0, 3, i != 0, i < 7);
            checks++;
            if ({cnt_out, tc, busy, done} !== ev[i]) begin
                errors++; $display("FAIL auto_reload[%0d] got %h exp %h", i, {cnt_out, tc, busy, done}, ev[i]);
            end
        end
    endtask

    task automatic test_random();
        int ci;
        bit ld;
        for (int i = 0; i < 400; i++) begin
            ld = ($urandom_range(0, 9) == 0);
            ci = ($urandom_range(0, 3) == 0) ? $urandom_range(0, (1 << W) - 1) : $urandom_range(0, 6);
            tick(ld, ci, $urandom_range(0, 3) != 0, $urandom_range(0, 1) == 1);
            checks++;
            if ({cnt_out, tc, busy, done} !== mv()) begin
                errors++; $display("FAIL random[%0d] got %h exp %h", i, {cnt_out, tc, busy, done}, mv());
            end
        end
    endtask

    initial begin
        model_reset();
        test_reset();
        test_reset_mid_count();
        test_one_shot();
        test_pause();
        test_collision_zero_load();
        test_auto_reload();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
